tlc_sensor_conditioner: RTL and testbench
=========================================

Name: tlc_sensor_conditioner

Overview:
Upstream stage of the 3-street traffic light controller. Conditions the three raw loop-detector inputs (EW straight, EW left, NS) into the clean ew_str_sensor / ew_left_sensor / ns_sensor levels that the controller consumes. Each lane is synchronized and debounced. A car that arrives while its lane is red is latched until the lane turns green. A sensor stuck high during its own green is flagged and masked, so the controller's 5-cycle timeout can still expire.

Parameters:
DEB_CYCLES, 3, consecutive synchronized samples required to change a filtered level (>=1)
STUCK_CYCLES, 64, consecutive filtered-high cycles during own green that declare a stuck sensor (>DEB_CYCLES)
CTR_W, 7, counter width; must satisfy 2**CTR_W > STUCK_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ew_str_raw  in  1  raw EW-straight detector, asynchronous to clk
ew_left_raw  in  1  raw EW-left detector, asynchronous to clk
ns_raw  in  1  raw NS detector, asynchronous to clk
ew_str_light  in  colors  current EW-straight light, fed back from the controller
ew_left_light  in  colors  current EW-left light
ns_light  in  colors  current NS light
ew_str_sensor  out  1  conditioned request to the controller
ew_left_sensor  out  1  conditioned request
ns_sensor  out  1  conditioned request
fault  out  3  sticky stuck-sensor flags, {ns, ew_left, ew_str}

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on posedge clk.
- On reset: all synchronizer flops, filtered levels, counters and latches go to 0; lane FSMs go to IDLE. All outputs read 0 in the cycle after the reset edge.
- Synchronizer: two flops per raw input. sync = second flop.
- Debounce, per lane: counter deb_ctr.
  - If sync == filt, deb_ctr <= 0.
  - Otherwise deb_ctr increments. When deb_ctr == DEB_CYCLES-1 and sync still != filt, filt <= sync and deb_ctr <= 0.
  - A glitch shorter than DEB_CYCLES never changes filt.
  - Latency from raw change to filt change is 2+DEB_CYCLES clocks.
- Lane FSM (states IDLE, ARMED, SERVING, FAULT). "Green" means the lane's light input == green.
  - IDLE: green -> SERVING; else filt=1 -> ARMED.
  - ARMED: stays until green, then -> SERVING. filt dropping does not clear the request.
  - SERVING: light != green -> IDLE; filt=1 for STUCK_CYCLES consecutive cycles -> FAULT. The stuck counter clears whenever filt=0 or the lane leaves SERVING.
  - FAULT: exit only when filt=0 (-> IDLE) or on reset.
- Output, registered from the current state:
  - IDLE: filt
  - ARMED: 1
  - SERVING: filt
  - FAULT: 0
- fault[i]: set on entry to FAULT; cleared only by reset (sticky even after the lane leaves FAULT).
- Yellow and red both count as "not green". If a lane enters green and filt rises in the same cycle, SERVING takes priority; the request is considered served.
- If the light is green from reset, the lane goes IDLE -> SERVING on the first cycle.
- Counters saturate and never wrap; they stop at their terminal value.
- Lanes are fully independent; several lanes may be ARMED at once, and the controller arbitrates.
- Invalid light encodings are treated as not green.

Decomposition:
- light_package (shared): colors (already exists); add a lane_state_t enum {IDLE, ARMED, SERVING, FAULT}.
- Sub-module tlc_lane_filter: one lane's synchronizer, debounce, FSM and stuck counter, parameterized by DEB_CYCLES, STUCK_CYCLES and CTR_W. The top instantiates it three times and concatenates the fault bits.

Test Plan:
- Debounce: with DEB_CYCLES=3, hold ns_raw=1 from edge 0 with ns_light=red -> ns_sensor=0 through edge 4, =1 after edge 5. A 2-cycle pulse on ns_raw -> ns_sensor stays 0.
- Request latch: ew_left_raw high for 10 cycles then low, ew_left_light=red -> ew_left_sensor stays 1. Set ew_left_light=green -> sensor follows filt (0) the next cycle; state returns to IDLE when the light goes yellow.
- Served presence: ew_str_light=green, ew_str_raw 1 then 0 -> ew_str_sensor falls 5 cycles after the raw fall, enabling the controller's 5-cycle timeout.
- Stuck sensor: with STUCK_CYCLES=64, ns_light=green and ns_raw held 1 -> ns_sensor=1 for 64 cycles after filt rises, then 0 with fault[2]=1. Release ns_raw -> lane IDLE, fault[2] remains 1 until reset.
- Reset mid-operation: assert reset for 1 cycle while ew_left is ARMED and ns is in FAULT -> all sensors 0 and fault=3'b000 the next cycle. Raw levels still high re-arm the lanes after 2+DEB_CYCLES cycles.
- Simultaneous lanes: all three raw inputs high, all lights red -> all three sensors reach 1 on the same cycle and remain 1 until each respective light turns green.

Source files
------------

// File: rtl/tlc_sensor_conditioner_pkg.sv
// tlc_sensor_conditioner_pkg: shared light colours and lane-conditioner FSM states
// colors       : light encoding fed back from the controller (2'b11 is invalid, never green)
// lane_state_t : per-lane request state
package tlc_sensor_conditioner_pkg;
   typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} colors;
   typedef enum logic [1:0] {IDLE, ARMED, SERVING, FAULT} lane_state_t;
endpackage

// File: rtl/tlc_lane_filter.sv
// tlc_lane_filter: one lane's synchronizer, debounce, request FSM and stuck-sensor detector
// clk, reset : system clock, synchronous active-high reset
// raw        : asynchronous loop-detector input
// light      : this lane's light, fed back from the controller
// sensor     : registered conditioned request
// fault      : sticky stuck-sensor flag
module tlc_lane_filter
   import tlc_sensor_conditioner_pkg::*;
#(
   parameter int DEB_CYCLES   = 3,
   parameter int STUCK_CYCLES = 64,
   parameter int CTR_W        = 7
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  raw,
   input  colors light,
   output logic  sensor,
   output logic  fault
);
   localparam logic [CTR_W-1:0] DEB_LAST   = CTR_W'(DEB_CYCLES - 1);
   localparam logic [CTR_W-1:0] STUCK_LAST = CTR_W'(STUCK_CYCLES - 1);

   logic             s1, s2, filt, green;
   logic [CTR_W-1:0] deb_ctr, stuck_ctr;
   lane_state_t      state, state_n;

   assign green = light == GREEN;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = green ? SERVING : filt ? ARMED : IDLE;
         ARMED:   state_n = green ? SERVING : ARMED;
         SERVING: state_n = !green ? IDLE : (filt && stuck_ctr == STUCK_LAST) ? FAULT : SERVING;
         FAULT:   state_n = filt ? FAULT : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         filt      <= 1'b0;
         deb_ctr   <= '0;
         stuck_ctr <= '0;
         state     <= IDLE;
         sensor    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == filt) begin
            deb_ctr <= '0;
         end else if (deb_ctr == DEB_LAST) begin
            filt    <= s2;
            deb_ctr <= '0;
         end else begin
            deb_ctr <= deb_ctr + CTR_W'(1);
         end
         // counts only while staying in SERVING with the filtered level high
         stuck_ctr <= (state == SERVING && state_n == SERVING && filt)
                      ? ((stuck_ctr == STUCK_LAST) ? stuck_ctr : stuck_ctr + CTR_W'(1)) : '0;
         state  <= state_n;
         sensor <= (state == ARMED) || (filt && (state == IDLE || state == SERVING));
         fault  <= fault | (state_n == FAULT);
      end
   end
endmodule

// File: rtl/tlc_sensor_conditioner.sv
// tlc_sensor_conditioner: conditions the three raw loop detectors into controller requests
// clk, reset                              : system clock, synchronous active-high reset
// ew_str_raw, ew_left_raw, ns_raw         : asynchronous raw detectors
// ew_str_light, ew_left_light, ns_light   : current lights from the controller
// ew_str_sensor, ew_left_sensor, ns_sensor: conditioned requests
// fault                                   : sticky stuck flags {ns, ew_left, ew_str}
module tlc_sensor_conditioner
   import tlc_sensor_conditioner_pkg::*;
#(
   parameter int DEB_CYCLES   = 3,
   parameter int STUCK_CYCLES = 64,
   parameter int CTR_W        = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ew_str_raw,
   input  logic       ew_left_raw,
   input  logic       ns_raw,
   input  colors      ew_str_light,
   input  colors      ew_left_light,
   input  colors      ns_light,
   output logic       ew_str_sensor,
   output logic       ew_left_sensor,
   output logic       ns_sensor,
   output logic [2:0] fault
);
   tlc_lane_filter #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES), .CTR_W(CTR_W)) u_ew_str (
      .clk(clk), .reset(reset), .raw(ew_str_raw), .light(ew_str_light),
      .sensor(ew_str_sensor), .fault(fault[0])
   );

   tlc_lane_filter #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES), .CTR_W(CTR_W)) u_ew_left (
      .clk(clk), .reset(reset), .raw(ew_left_raw), .light(ew_left_light),
      .sensor(ew_left_sensor), .fault(fault[1])
   );

   tlc_lane_filter #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES), .CTR_W(CTR_W)) u_ns (
      .clk(clk), .reset(reset), .raw(ns_raw), .light(ns_light),
      .sensor(ns_sensor), .fault(fault[2])
   );
endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// tb_tlc_sensor_conditioner: randomized and directed check of the sensor conditioner against a lane model
module tb_tlc_sensor_conditioner;
   import tlc_sensor_conditioner_pkg::*;

   localparam int DEB   = 3;
   localparam int STUCK = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       ew_str_raw, ew_left_raw, ns_raw;
   colors      ew_str_light, ew_left_light, ns_light;
   logic       ew_str_sensor, ew_left_sensor, ns_sensor;
   logic [2:0] fault;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // model per lane (0 ew_str, 1 ew_left, 2 ns)
   int m_pipe1[3], m_pipe2[3], m_filt[3], m_run[3];
   int m_pend[3], m_serv[3], m_masked[3], m_stuck[3], m_sens[3], m_fault[3];

   tlc_sensor_conditioner dut (
      .clk(clk), .reset(reset),
      .ew_str_raw(ew_str_raw), .ew_left_raw(ew_left_raw), .ns_raw(ns_raw),
      .ew_str_light(ew_str_light), .ew_left_light(ew_left_light), .ns_light(ns_light),
      .ew_str_sensor(ew_str_sensor), .ew_left_sensor(ew_left_sensor), .ns_sensor(ns_sensor),
      .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_edge(input bit rst, input bit rw[3], input bit g[3]);
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_pipe1[i] = 0; m_pipe2[i] = 0; m_filt[i] = 0; m_run[i] = 0;
            m_pend[i] = 0; m_serv[i] = 0; m_masked[i] = 0; m_stuck[i] = 0;
            m_sens[i] = 0; m_fault[i] = 0;
         end else begin
            int sync = m_pipe2[i];
            int f    = m_filt[i];
            // request asserted when latched, or when filtered high and not masked
            m_sens[i] = (!m_masked[i] && (m_pend[i] != 0 || f != 0)) ? 1 : 0;
            if (m_masked[i] != 0) begin
               if (f == 0) m_masked[i] = 0;
            end else if (m_serv[i] != 0) begin
               if (!g[i]) begin
                  m_serv[i] = 0; m_stuck[i] = 0;
               end else if (f != 0) begin
                  m_stuck[i]++;
                  if (m_stuck[i] == STUCK) begin
                     m_masked[i] = 1; m_serv[i] = 0; m_stuck[i] = 0; m_fault[i] = 1;
                  end
               end else begin
                  m_stuck[i] = 0;
               end
            end else if (g[i]) begin
               m_serv[i] = 1; m_pend[i] = 0; m_stuck[i] = 0;
            end else if (f != 0) begin
               m_pend[i] = 1;
            end
            m_pipe2[i] = m_pipe1[i];
            m_pipe1[i] = rw[i] ? 1 : 0;
            // filtered level flips after DEB consecutive disagreeing samples
            if (sync != f) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_filt[i] = sync; m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
   endtask

   task automatic step();
      bit rw[3];
      bit g[3];
      bit rst;
      rst = reset;
      rw[0] = ew_str_raw; rw[1] = ew_left_raw; rw[2] = ns_raw;
      g[0] = ew_str_light == GREEN; g[1] = ew_left_light == GREEN; g[2] = ns_light == GREEN;
      @(posedge clk);
      model_edge(rst, rw, g);
      cyc++;
      #1;
      chk("ew_str_sensor", int'(ew_str_sensor), m_sens[0]);
      chk("ew_left_sensor", int'(ew_left_sensor), m_sens[1]);
      chk("ns_sensor", int'(ns_sensor), m_sens[2]);
      chk("fault", int'(fault), m_fault[2] * 4 + m_fault[1] * 2 + m_fault[0]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int hi;
      int p;
      reset = 1'b1;
      ew_str_raw = 0; ew_left_raw = 0; ns_raw = 0;
      ew_str_light = RED; ew_left_light = RED; ns_light = RED;
      do_reset();
      chk("reset_sensors", int'({ew_str_sensor, ew_left_sensor, ns_sensor}), 0);
      chk("reset_fault", int'(fault), 0);

      // debounce latency
      ns_raw = 1;
      for (int e = 0; e <= 5; e++) begin
         step();
         chk("deb_latency", int'(ns_sensor), (e == 5) ? 1 : 0);
      end

      // short glitch
      ns_raw = 0;
      do_reset();
      ew_str_raw = 1; step(); step();
      ew_str_raw = 0;
      hi = 0;
      repeat (10) begin step(); hi += int'(ew_str_sensor); end
      chk("glitch_ignored", hi, 0);

      // request latch on red
      do_reset();
      ew_left_raw = 1; repeat (10) step();
      ew_left_raw = 0; repeat (10) step();
      chk("latched_on_red", int'(ew_left_sensor), 1);
      ew_left_light = GREEN; step();
      chk("armed_until_served", int'(ew_left_sensor), 1);
      step();
      chk("served_follows_filt", int'(ew_left_sensor), 0);
      ew_left_light = YELLOW; repeat (4) step();
      ew_left_light = RED;

      // served presence drops after raw falls
      do_reset();
      ew_str_light = GREEN;
      ew_str_raw = 1; repeat (8) step();
      ew_str_raw = 0;
      repeat (5) step();
      chk("presence_held", int'(ew_str_sensor), 1);
      step();
      chk("presence_dropped", int'(ew_str_sensor), 0);
      ew_str_light = RED;

      // stuck sensor during own green
      ns_light = GREEN;
      do_reset();
      ns_raw = 1;
      hi = 0;
      repeat (90) begin step(); hi += int'(ns_sensor); end
      chk("stuck_high_cycles", hi, STUCK);
      chk("stuck_fault", int'(fault), 3'b100);

      // reset mid-operation with ew_left armed and ns faulted
      ew_left_raw = 1; repeat (10) step();
      chk("armed_before_reset", int'(ew_left_sensor), 1);
      reset = 1; step(); reset = 0;
      chk("midreset_sensors", int'({ew_str_sensor, ew_left_sensor, ns_sensor}), 0);
      chk("midreset_fault", int'(fault), 0);
      repeat (6) step();
      chk("rearm_after_reset", int'(ew_left_sensor), 1);

      // fault stays sticky after release
      ns_raw = 1; repeat (80) step();
      ns_raw = 0; repeat (10) step();
      chk("fault_sticky", int'(fault[2]), 1);

      // simultaneous lanes
      ew_str_raw = 0; ew_left_raw = 0;
      ns_light = RED;
      do_reset();
      ew_str_raw = 1; ew_left_raw = 1; ns_raw = 1;
      repeat (5) step();
      chk("all_pending_early", int'({ew_str_sensor, ew_left_sensor, ns_sensor}), 0);
      step();
      chk("all_pending", int'({ew_str_sensor, ew_left_sensor, ns_sensor}), 3'b111);
      ew_str_raw = 0; ew_left_raw = 0; ns_raw = 0;
      repeat (12) step();
      chk("all_still_pending", int'({ew_str_sensor, ew_left_sensor, ns_sensor}), 3'b111);
      ew_str_light = GREEN; repeat (6) step();
      ew_left_light = GREEN; repeat (6) step();
      ns_light = colors'(2'd3); repeat (6) step();
      chk("invalid_not_green", int'(ns_sensor), 1);
      ns_light = GREEN; repeat (6) step();

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         p = ((k / 300) % 2 != 0) ? 200 : 6;
         if ($urandom_range(0, p - 1) == 0) ew_str_raw = ~ew_str_raw;
         if ($urandom_range(0, p - 1) == 0) ew_left_raw = ~ew_left_raw;
         if ($urandom_range(0, p - 1) == 0) ns_raw = ~ns_raw;
         if ($urandom_range(0, 59) == 0) ew_str_light = colors'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) ew_left_light = colors'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) ns_light = colors'($urandom_range(0, 3));
         reset = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
